// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : CPU data-memory bus plus output-FIFO stream handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if #(
    parameter int N = 32
);
    logic [N-1:0] mem_address_i;
    logic [N-1:0] mem_in_data_i;
    logic         mem_WE_i;
    logic [N-1:0] mem_out_data_o;
    logic         out_valid_o;
    logic [N-1:0] out_data_o;
    logic         out_ready_i;

    modport slave (
        input  mem_address_i,
        input  mem_in_data_i,
        input  mem_WE_i,
        input  out_ready_i,
        output mem_out_data_o,
        output out_valid_o,
        output out_data_o
    );

    modport master (
        output mem_address_i,
        output mem_in_data_i,
        output mem_WE_i,
        output out_ready_i,
        input  mem_out_data_o,
        input  out_valid_o,
        input  out_data_o
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word RAM plus MMIO window (TX FIFO, STATUS, CYCLES, CTRL) for
//               the CPU data port. Cycle counter built only when
//               DMEM_CYCLE_COUNTER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int           N          = 32,
    parameter int           DEPTH      = 1024,
    parameter int           FIFO_DEPTH = 8,
    parameter logic [N-1:0] MMIO_BASE  = 32'hFFFF_FFF0
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    data_mem_responder_if.slave bus
);

    localparam int         AW         = $clog2(DEPTH);
    localparam int         PTR_W      = $clog2(FIFO_DEPTH);
    localparam int         CNT_W      = PTR_W + 1;
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLES = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    logic [N-1:0] ram_q [DEPTH];
    logic [N-1:0] fifo_q [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             bad_q, bad_d;

    logic [N-1:0] w_addr;
    logic [N-1:0] w_off;
    logic         w_is_ram;
    logic         w_is_mmio;
    logic [1:0]   w_reg;
    logic         w_wr;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_push_req;
    logic         w_push;
    logic         w_status_wr;
    logic         w_bad_wr;
    logic [31:0]  w_cnt_ext;
    logic [3:0]   w_cnt_sat;
    logic [N-1:0] w_status;
    logic [N-1:0] w_cycles;
    logic [N-1:0] w_rdata;

    // RAM has priority should the MMIO window ever overlap it.
    assign w_addr    = bus.mem_address_i;
    assign w_off     = w_addr - MMIO_BASE;
    assign w_is_ram  = w_addr < N'(DEPTH);
    assign w_is_mmio = !w_is_ram && (w_off < N'(4));
    assign w_reg     = w_off[1:0];
    assign w_wr      = bus.mem_WE_i && !RST;

    assign w_full      = count_q == CNT_W'(FIFO_DEPTH);
    assign w_empty     = count_q == '0;
    assign w_pop       = !w_empty && bus.out_ready_i;
    assign w_push_req  = w_wr && w_is_mmio && (w_reg == REG_TXDATA);
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_status_wr = w_wr && w_is_mmio && (w_reg == REG_STATUS);
    assign w_bad_wr    = w_wr && !w_is_ram && !w_is_mmio;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
        count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        ovf_d    = ovf_q;
        bad_d    = bad_q;
        if (w_status_wr) begin
            ovf_d = 1'b0;
            bad_d = 1'b0;
        end else begin
            if (w_push_req && !w_push) begin
                ovf_d = 1'b1;
            end
            if (w_bad_wr) begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            bad_q    <= bad_d;
        end
    end

    // Storage arrays carry no reset; empty FIFO output is gated to zero below.
    always_ff @(posedge CLK) begin
        if (w_wr && w_is_ram) begin
            ram_q[w_addr[AW-1:0]] <= bus.mem_in_data_i;
        end
        if (w_push) begin
            fifo_q[wr_ptr_q] <= bus.mem_in_data_i;
        end
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [N-1:0] cyc_q, cyc_d;
    logic         w_ctrl_clr;

    assign w_ctrl_clr = w_wr && w_is_mmio && (w_reg == REG_CTRL) && bus.mem_in_data_i[0];

    always_comb begin
        cyc_d = w_ctrl_clr ? '0 : cyc_q + N'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign w_cycles = cyc_q;
`else
    assign w_cycles = '0;
`endif

    assign w_cnt_ext = 32'(count_q);
    assign w_cnt_sat = (w_cnt_ext > 32'd15) ? 4'hF : w_cnt_ext[3:0];
    assign w_status  = {{(N-8){1'b0}}, w_cnt_sat, bad_q, ovf_q, w_empty, w_full};

    always_comb begin
        w_rdata = '0;
        if (w_is_ram) begin
            w_rdata = ram_q[w_addr[AW-1:0]];
        end else if (w_is_mmio) begin
            case (w_reg)
                REG_STATUS: w_rdata = w_status;
                REG_CYCLES: w_rdata = w_cycles;
                default:    w_rdata = '0;
            endcase
        end
    end

    assign bus.mem_out_data_o = w_rdata;
    assign bus.out_valid_o    = !w_empty;
    assign bus.out_data_o     = w_empty ? '0 : fifo_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed plus randomized bench for data_mem_responder against
//               a queue/array reference model. Honours DMEM_CYCLE_COUNTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int          N       = 32;
    localparam int          DEPTH   = 1024;
    localparam int          FD      = 8;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [31:0] BASE    = 32'hFFFF_FFF0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if #(.N(N)) bus ();

    data_mem_responder #(
        .N          (N),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FD),
        .MMIO_BASE  (BASE)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Reference model state
    logic [31:0] m_q[$];
    logic [31:0] m_ram[logic [31:0]];
    bit          m_ovf;
    bit          m_bad;
    logic [31:0] m_cyc;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    function automatic logic [31:0] m_status();
        int          sz;
        logic [3:0]  cnt;
        sz  = m_q.size();
        cnt = (sz > 15) ? 4'hF : 4'(sz);
        return {24'b0, cnt, m_bad, m_ovf, sz == 0, sz == FD};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < DEPTH_W) return m_ram[a];
        if (a == BASE + 32'd1) return m_status();
`ifdef DMEM_CYCLE_COUNTER_EN
        if (a == BASE + 32'd2) return m_cyc;
`endif
        return 32'd0;
    endfunction

    function automatic void m_edge(input logic [31:0] a, input logic [31:0] d,
                                   input logic we, input logic rdy, input logic rs);
        bit pop;
        if (rs) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_bad = 1'b0;
            m_cyc = 32'd0;
            return;
        end
        pop = (m_q.size() != 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (we) begin
            if (a < DEPTH_W) m_ram[a] = d;
            else if (a == BASE) begin
                if (m_q.size() < FD) m_q.push_back(d);
                else m_ovf = 1'b1;
            end else if (a == BASE + 32'd1) begin
                m_ovf = 1'b0;
                m_bad = 1'b0;
            end else if (a != BASE + 32'd2 && a != BASE + 32'd3) begin
                m_bad = 1'b1;
            end
        end
        m_cyc = (we && a == BASE + 32'd3 && d[0]) ? 32'd0 : m_cyc + 32'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the negedge, check just after, then advance the model.
    task automatic step(input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic rdy, input logic rs);
        bus.mem_address_i = a;
        bus.mem_in_data_i = d;
        bus.mem_WE_i      = we;
        bus.out_ready_i   = rdy;
        rst               = rs;
        #1;
        if (a >= DEPTH_W || m_ram.exists(a)) chk("rdata", bus.mem_out_data_o, m_read(a));
        chk("valid", 32'(bus.out_valid_o), 32'(m_q.size() != 0));
        chk("head", bus.out_data_o, (m_q.size() != 0) ? m_q[0] : 32'd0);
        @(posedge clk);
        m_edge(a, d, we, rdy, rs);
        @(negedge clk);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.mem_address_i = a;
        bus.mem_WE_i      = 1'b0;
        #1;
        chk(tag, bus.mem_out_data_o, exp);
    endtask

    initial begin
        logic [31:0] last;
        logic [31:0] a;
        int          sel;

        rst               = 1'b1;
        bus.mem_address_i = '0;
        bus.mem_in_data_i = '0;
        bus.mem_WE_i      = 1'b0;
        bus.out_ready_i   = 1'b0;
        m_ovf = 1'b0;
        m_bad = 1'b0;
        m_cyc = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        step(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        peek("status_reset", BASE + 32'd1, 32'h02);

        // RAM write/read, out-of-range read
        step(32'd0, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
        step(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        peek("ram5", 32'd5, 32'hDEAD_BEEF);
        peek("ram_oob", DEPTH_W, 32'd0);

        // Queue three words, then drain in order
        for (int i = 1; i <= 3; i++) step(BASE, 32'(i), 1'b1, 1'b0, 1'b0);
        peek("status_3", BASE + 32'd1, 32'h30);
        for (int i = 1; i <= 3; i++) begin
            chk("drain_order", bus.out_data_o, 32'(i));
            step(32'd5, 32'd0, 1'b0, 1'b1, 1'b0);
        end
        chk("drained_valid", 32'(bus.out_valid_o), 32'd0);
        peek("status_empty", BASE + 32'd1, 32'h02);

        // Overflow on ninth push, cleared by STATUS write
        for (int i = 0; i < 9; i++) step(BASE, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
        peek("status_ovf", BASE + 32'd1, 32'h85);
        step(BASE + 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        peek("status_clr", BASE + 32'd1, 32'h81);

        // Push and pop together while full, wrapping pointers
        step(BASE, 32'hA5, 1'b1, 1'b1, 1'b0);
        peek("status_pp", BASE + 32'd1, 32'h81);
        last = 32'd0;
        for (int i = 0; i < FD; i++) begin
            last = bus.out_data_o;
            step(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        end
        chk("last_word", last, 32'hA5);
        chk("empty_after", 32'(bus.out_valid_o), 32'd0);

        // Unmapped write sets bad_access and leaves RAM alone
        step(32'h0001_0000, 32'd77, 1'b1, 1'b0, 1'b0);
        peek("status_bad", BASE + 32'd1, 32'h0A);
        peek("ram0_kept", 32'd0, 32'h0000_1234);

        // Reset mid-stream; write on the reset edge must be ignored
        for (int i = 0; i < 4; i++) step(BASE, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0);
        step(32'd5, 32'd0, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        peek("rst_status", BASE + 32'd1, 32'h02);
        peek("rst_ram5", 32'd5, 32'hDEAD_BEEF);

        // Cycle counter clear then ten edges
        step(BASE + 32'd3, 32'd1, 1'b1, 1'b0, 1'b0);
        repeat (10) step(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef DMEM_CYCLE_COUNTER_EN
        peek("cycles", BASE + 32'd2, 32'd10);
`else
        peek("cycles", BASE + 32'd2, 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3: a = 32'($urandom_range(0, 15));
                4:          a = DEPTH_W - 32'd1;
                5:          a = DEPTH_W;
                6, 7, 8:    a = BASE + 32'($urandom_range(0, 3));
                default:    a = ($urandom_range(0, 1) != 0) ? 32'h0001_0000 : 32'hFFFF_FFEF;
            endcase
            step(a, $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Target side of the CPU data-memory port. Answers the core's word-addressed load/store requests: address, write data, write enable in; read data out.
- Contains a word RAM and a small MMIO window.
- MMIO window provides an output FIFO that streams stored words to a host/display consumer, plus status and cycle-counter registers.
- Instantiated beside the CPU at top level; connects directly to the CPU's data_mem_* pins.

Parameters:
- N, 32, data/address width.
- DEPTH, 1024, RAM size in words; RAM occupies word addresses 0..DEPTH-1.
- FIFO_DEPTH, 8, output FIFO entries; must be a power of 2, minimum 2.
- MMIO_BASE, 32'hFFFF_FFF0, base word address of the 4-word MMIO window.

Ports:
- CLK  input  1  clock
- RST  input  1  reset, synchronous, active-high
- mem_address_i  input  N  word address from CPU (MEM stage ALU result)
- mem_in_data_i  input  N  store data from CPU
- mem_WE_i  input  1  store strobe
- mem_out_data_o  output  N  load data to CPU
- out_valid_o  output  1  FIFO head valid
- out_data_o  output  N  FIFO head word
- out_ready_i  input  1  consumer accepts the head word

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reads: mem_out_data_o is combinational from mem_address_i in the same cycle; the CPU captures it at the next CLK edge. No wait states.
- Writes: take effect on the CLK edge where mem_WE_i=1.
- Address map (word addresses):
  - 0..DEPTH-1: RAM, read/write.
  - MMIO_BASE+0 (TXDATA): a write pushes mem_in_data_i into the FIFO; reads return 0.
  - MMIO_BASE+1 (STATUS): read-only fields are [0] full, [1] empty, [2] overflow (sticky), [3] bad_access (sticky), [7:4] count (saturates at 15), all other bits 0. Any write clears the overflow and bad_access bits.
  - MMIO_BASE+2 (CYCLES): free-running cycle counter; see Optional Feature.
  - MMIO_BASE+3 (CTRL): a write with bit0=1 clears CYCLES to 0 on that edge; reads return 0.
  - Any other address: reads return 0, writes are ignored. A write to such an address sets bad_access. Reads never set flags.
- FIFO:
  - First-word fall-through: out_valid_o = !empty, out_data_o = head entry (0 when empty).
  - A pop occurs on an edge where out_valid_o & out_ready_i.
  - A push occurs on an edge where TXDATA is written and (!full or a pop occurs on the same edge).
  - Pushed word is visible on out_valid_o/out_data_o the cycle after the push edge when the FIFO was empty.
  - Push while full with no pop: word dropped, overflow set, count unchanged.
  - Simultaneous push and pop: count unchanged; wraps correctly at pointer boundaries (pointers mod FIFO_DEPTH).
  - Pop while empty is impossible because out_valid_o=0.
- Reset (any cycle, including mid-stream):
  - FIFO pointers and count go to 0; out_valid_o=0, out_data_o=0.
  - overflow and bad_access go to 0; CYCLES goes to 0.
  - RAM contents are NOT cleared.
  - mem_out_data_o remains combinational. Writes on a reset edge are ignored.
- Counter: CYCLES increments by 1 every non-reset edge and wraps 2^N-1 -> 0. If a CTRL clear and an increment hit the same edge, the clear wins (value 0).

Optional Feature:
- Macro: DMEM_CYCLE_COUNTER_EN.
- Defined: CYCLES counter and CTRL clear are implemented as described above.
- Undefined: no counter hardware; CYCLES reads return 0. Writes to CTRL are accepted silently and do not set bad_access. All other behaviour is unchanged.

Test Plan:
- Write 32'hDEAD_BEEF to address 5, then read address 5 the next cycle -> mem_out_data_o=32'hDEAD_BEEF combinationally. Read address DEPTH -> 0.
- Push 1,2,3 to TXDATA with out_ready_i=0 -> STATUS=32'h30 (count 3, not empty). Raise out_ready_i -> out_data_o presents 1,2,3 on consecutive cycles, then out_valid_o=0 and STATUS=32'h02.
- Push 9 words with out_ready_i=0 and FIFO_DEPTH=8 -> 9th word dropped, STATUS=32'h85 (count 8, full, overflow). Write STATUS -> overflow cleared, STATUS=32'h81.
- FIFO full, push 32'hA5 with out_ready_i=1 on the same edge -> count stays 8, head advances. After draining, the last word out is 32'hA5. Exercises pointer wrap.
- Write address 32'h0001_0000 -> bad_access set, STATUS bit3=1, RAM unchanged. Assert RST with 4 words queued -> next cycle out_valid_o=0, STATUS=32'h02, RAM word 5 still 32'hDEAD_BEEF.
- With DMEM_CYCLE_COUNTER_EN defined: write CTRL=1, wait 10 edges, read CYCLES -> 10. Undefined -> CYCLES reads 0.
